// File: rtl/instr_register_pkg.sv
// +--------------------------------------------------------------------------+
// | instr_register_pkg: shared instruction types and register geometry.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package instr_register_pkg;

  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// +--------------------------------------------------------------------------+
// | rr_arb2: two-way arbiter, round-robin by default; INSTR_SCHED_FIXED_PRI_EN|
// | selects fixed priority (req[0] wins).  Revision: 1.0                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef INSTR_SCHED_FIXED_PRI_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset_n};

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0]) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end
  end
`else
  // last_grant_q = 1 means req[1] won most recently, so req[0] takes the next tie.
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    last_grant_d = last_grant_q;
    if (grant[0]) begin
      last_grant_d = 1'b0;
    end else if (grant[1]) begin
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/instr_reg_sched.sv
// +--------------------------------------------------------------------------+
// | instr_reg_sched: arbitrates two producers onto instr_register as a       |
// | circular queue with a valid/ready consumer port. Macro: INSTR_SCHED_FIXED_PRI_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_reg_sched
  import instr_register_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  opcode_t           req0_opcode,
  input  operand_t          req0_op_a,
  input  operand_t          req0_op_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  opcode_t           req1_opcode,
  input  operand_t          req1_op_a,
  input  operand_t          req1_op_b,
  output logic              req1_ready,
  output logic              load_en,
  output opcode_t           opcode,
  output operand_t          operand_a,
  output operand_t          operand_b,
  output logic [ADDR_W-1:0] write_pointer,
  output logic [ADDR_W-1:0] read_pointer,
  input  instruction_t      instruction_word,
  output logic              out_valid,
  output instruction_t      out_instr,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W+1:0] CAPACITY = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic                load_en_q,       load_en_d;
  instruction_t        wr_data_q,       wr_data_d;
  logic [ADDR_W-1:0]   write_pointer_q, write_pointer_d;
  logic [ADDR_W-1:0]   wr_ptr_q,        wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q,        rd_ptr_d;
  logic [ADDR_W:0]     count_q,         count_d;

  logic [ADDR_W+1:0]   occupancy;
  logic                space;
  logic [1:0]          grant;
  logic                transfer;
  logic                pop;

  // The in-flight write already owns a slot, so it counts toward capacity.
  assign occupancy = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, load_en_q};
  assign space     = occupancy < CAPACITY;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (space && reset_n),
    .req     ({req1_valid, req0_valid}),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign transfer   = |grant;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    load_en_d       = transfer;
    wr_data_d       = wr_data_q;
    write_pointer_d = write_pointer_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    if (grant[0]) begin
      wr_data_d = '{opc: req0_opcode, op_a: req0_op_a, op_b: req0_op_b};
    end else if (grant[1]) begin
      wr_data_d = '{opc: req1_opcode, op_a: req1_op_a, op_b: req1_op_b};
    end
    if (transfer) begin
      write_pointer_d = wr_ptr_q;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    count_d = count_q + {{ADDR_W{1'b0}}, load_en_q} - {{ADDR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en_q       <= 1'b0;
      wr_data_q       <= '{opc: ZERO, op_a: '0, op_b: '0};
      write_pointer_q <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      load_en_q       <= load_en_d;
      wr_data_q       <= wr_data_d;
      write_pointer_q <= write_pointer_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  assign load_en       = load_en_q;
  assign opcode        = wr_data_q.opc;
  assign operand_a     = wr_data_q.op_a;
  assign operand_b     = wr_data_q.op_b;
  assign write_pointer = write_pointer_q;
  assign read_pointer  = rd_ptr_q;
  assign out_instr     = instruction_word;
  assign count         = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_reg_sched.sv
// +--------------------------------------------------------------------------+
// | tb_instr_reg_sched: directed bench for instr_reg_sched with a behavioural |
// | instr_register.  Revision: 1.0                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_reg_sched;
  import instr_register_pkg::*;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NV     = 10;

`ifdef INSTR_SCHED_FIXED_PRI_EN
  localparam logic [1:0] TIE_B = 2'b01;
`else
  localparam logic [1:0] TIE_B = 2'b10;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req0_valid, req1_valid;
  opcode_t           req0_opcode, req1_opcode;
  operand_t          req0_op_a, req0_op_b, req1_op_a, req1_op_b;
  logic              req0_ready, req1_ready;
  logic              load_en;
  opcode_t           opcode;
  operand_t          operand_a, operand_b;
  logic [ADDR_W-1:0] write_pointer, read_pointer;
  instruction_t      instruction_word;
  logic              out_valid;
  instruction_t      out_instr;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              full, empty;

  always #5 clk = ~clk;

  instr_reg_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req0_valid       (req0_valid),
    .req0_opcode      (req0_opcode),
    .req0_op_a        (req0_op_a),
    .req0_op_b        (req0_op_b),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_opcode      (req1_opcode),
    .req1_op_a        (req1_op_a),
    .req1_op_b        (req1_op_b),
    .req1_ready       (req1_ready),
    .load_en          (load_en),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_instr        (out_instr),
    .out_ready        (out_ready),
    .count            (count),
    .full             (full),
    .empty            (empty)
  );

  // Behavioural instr_register: synchronous write, combinational read.
  instruction_t mem [DEPTH];
  always @(posedge clk) begin
    if (load_en) mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b};
  end
  assign instruction_word = mem[read_pointer];

  typedef struct {
    logic         r0v;
    instruction_t r0;
    logic         r1v;
    instruction_t r1;
    logic         ordy;
    logic [1:0]   g;
    int           cnt;
  } vec_t;

  vec_t         tbl [NV];
  int           passed = 0;
  int           total  = 0;
  int           wp_m = 0, rp_m = 0, cnt_m = 0;
  logic         ld_m = 1'b0;
  instruction_t sb [$];
  logic [4:0]   last_wp = 5'd0;
  logic         wrap_seen = 1'b0;

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t r;
    r.opc  = o;
    r.op_a = a;
    r.op_b = b;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_req(input logic v0, input instruction_t p0, input logic v1,
                         input instruction_t p1, input logic ordy);
    req0_valid  = v0;
    req0_opcode = p0.opc;
    req0_op_a   = p0.op_a;
    req0_op_b   = p0.op_b;
    req1_valid  = v1;
    req1_opcode = p1.opc;
    req1_op_a   = p1.op_a;
    req1_op_b   = p1.op_b;
    out_ready   = ordy;
  endtask

  task automatic reset_models();
    wp_m  = 0;
    rp_m  = 0;
    cnt_m = 0;
    ld_m  = 1'b0;
    sb.delete();
  endtask

  // One clock: check handshake against the occupancy model, then the registered results.
  task automatic do_cycle(output logic [1:0] g);
    logic         pop_m, space_m;
    instruction_t pay;
    #1;
    g       = {req1_valid && req1_ready, req0_valid && req0_ready};
    space_m = (cnt_m + int'(ld_m)) < DEPTH;
    chk("grant_any", |g, space_m && (req0_valid || req1_valid));
    chk("grant_onehot", &g, 1'b0);
    chk("out_valid", out_valid, cnt_m != 0);
    pop_m = out_ready && (cnt_m != 0);
    if (pop_m && sb.size() > 0) begin
      chk("out_instr", out_instr, sb[0]);
      void'(sb.pop_front());
    end
    pay = g[0] ? mk(req0_opcode, req0_op_a, req0_op_b) : mk(req1_opcode, req1_op_a, req1_op_b);
    if (|g) sb.push_back(pay);
    @(posedge clk);
    #1;
    chk("load_en", load_en, |g);
    if (|g) begin
      chk("write_pointer", write_pointer, wp_m);
      chk("wr_data", {opcode, operand_a, operand_b}, pay);
      if (last_wp == 5'd31 && write_pointer == 5'd0) wrap_seen = 1'b1;
      last_wp = write_pointer;
      wp_m    = (wp_m + 1) % DEPTH;
    end
    if (pop_m) rp_m = (rp_m + 1) % DEPTH;
    chk("read_pointer", read_pointer, rp_m);
    cnt_m = cnt_m + int'(ld_m) - int'(pop_m);
    ld_m  = |g;
    chk("count", count, cnt_m);
    chk("full", full, cnt_m == DEPTH);
    chk("empty", empty, cnt_m == 0);
  endtask

  initial begin
    logic [1:0] g;
    int         acc;
    int         seq;
    logic [4:0] wp0, rp0;
    instruction_t nop;

    nop = mk(ZERO, 0, 0);
    tbl[0] = '{1'b1, mk(ADD, 5, 3),     1'b1, mk(SUB, 9, 2),   1'b0, 2'b01, 0};
    tbl[1] = '{1'b1, mk(PASSA, 7, 0),   1'b1, mk(SUB, 9, 2),   1'b0, TIE_B, 1};
    tbl[2] = '{1'b1, mk(PASSA, 7, 0),   1'b1, mk(MULT, -4, 6), 1'b0, 2'b01, 2};
    tbl[3] = '{1'b1, mk(DIV, 100, 7),   1'b1, mk(MULT, -4, 6), 1'b0, TIE_B, 3};
    tbl[4] = '{1'b0, nop,               1'b0, nop,             1'b1, 2'b00, 3};
    tbl[5] = '{1'b0, nop,               1'b0, nop,             1'b1, 2'b00, 2};
    tbl[6] = '{1'b0, nop,               1'b1, mk(MOD, -1, 3),  1'b1, 2'b10, 1};
    tbl[7] = '{1'b0, nop,               1'b0, nop,             1'b1, 2'b00, 1};
    tbl[8] = '{1'b0, nop,               1'b0, nop,             1'b1, 2'b00, 0};
    tbl[9] = '{1'b0, nop,               1'b0, nop,             1'b1, 2'b00, 0};

    // Reset state, with requests pending to prove ready stays low.
    reset_n = 1'b0;
    set_req(1'b1, mk(ADD, 1, 1), 1'b1, mk(SUB, 2, 2), 1'b0);
    #12;
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_load_en", load_en, 1'b0);
    chk("rst_wdata", {opcode, operand_a, operand_b}, 68'd0);
    chk("rst_ptrs", {write_pointer, read_pointer}, 10'd0);
    chk("rst_count", count, 0);
    chk("rst_flags", {empty, full, out_valid}, 3'b100);
    set_req(1'b0, nop, 1'b0, nop, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    reset_models();
    @(posedge clk);
    #1;

    // Table: tie arbitration, latency, in-order pops, simultaneous commit/pop, empty pop.
    for (int i = 0; i < NV; i++) begin
      set_req(tbl[i].r0v, tbl[i].r0, tbl[i].r1v, tbl[i].r1, tbl[i].ordy);
      do_cycle(g);
      chk($sformatf("tbl%0d_grant", i), g, tbl[i].g);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
    end

    // Fill to capacity with no consumer.
    seq = 100;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      set_req(1'b1, mk(ADD, seq, -seq), 1'b0, nop, 1'b0);
      do_cycle(g);
      if (g[0]) begin
        seq++;
        acc++;
      end
    end
    chk("fill_accepts", acc, 32);
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 32);
    set_req(1'b1, mk(ADD, seq, -seq), 1'b1, mk(SUB, 1, 2), 1'b0);
    #1;
    chk("full_ready", {req1_ready, req0_ready}, 2'b00);

    // Pop one: exactly one further write fits.
    set_req(1'b1, mk(ADD, seq, -seq), 1'b0, nop, 1'b1);
    do_cycle(g);
    chk("pop_full_grant", g, 2'b00);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, mk(ADD, seq, -seq), 1'b0, nop, 1'b0);
      do_cycle(g);
      if (g[0]) begin
        seq++;
        acc++;
      end
    end
    chk("refill_accepts", acc, 1);

    // Drain to 5, then commit and pop on the same edge.
    for (int i = 0; i < 27; i++) begin
      set_req(1'b0, nop, 1'b0, nop, 1'b1);
      do_cycle(g);
    end
    chk("drain5_count", count, 5);
    set_req(1'b1, mk(SUB, seq, 7), 1'b0, nop, 1'b0);
    do_cycle(g);
    seq++;
    wp0 = write_pointer;
    rp0 = read_pointer;
    set_req(1'b1, mk(MULT, seq, 8), 1'b0, nop, 1'b1);
    do_cycle(g);
    seq++;
    chk("sim_count", count, 5);
    chk("sim_wp", write_pointer, wp0 + 5'd1);
    chk("sim_rp", read_pointer, rp0 + 5'd1);

    // 40 writes interleaved with pops, crossing the pointer wrap.
    wrap_seen = 1'b0;
    acc = 0;
    for (int i = 0; i < 120 && acc < 40; i++) begin
      set_req(1'b1, mk(PASSB, seq, i), 1'b0, nop, (i % 3) != 0);
      do_cycle(g);
      if (g[0]) begin
        seq++;
        acc++;
      end
    end
    chk("wrap_accepts", acc, 40);
    for (int i = 0; i < 40; i++) begin
      set_req(1'b0, nop, 1'b0, nop, 1'b1);
      do_cycle(g);
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_empty", empty, 1'b1);
    chk("wrap_seen", wrap_seen, 1'b1);

    // Reset mid-stream while a write is in flight.
    set_req(1'b1, mk(DIV, 3, 4), 1'b0, nop, 1'b0);
    do_cycle(g);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_load_en", load_en, 1'b0);
    chk("mrst_count", count, 0);
    chk("mrst_ptrs", {write_pointer, read_pointer}, 10'd0);
    chk("mrst_flags", {empty, full, out_valid}, 3'b100);
    set_req(1'b1, mk(ADD, 1, 1), 1'b1, mk(SUB, 2, 2), 1'b0);
    #1;
    chk("mrst_ready", {req1_ready, req0_ready}, 2'b00);
    set_req(1'b0, nop, 1'b0, nop, 1'b0);
    reset_models();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    set_req(1'b1, mk(ADD, 11, 12), 1'b1, mk(SUB, 13, 14), 1'b0);
    do_cycle(g);
    chk("post_rst_tie", g, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_reg_sched.md
# instr_reg_sched

Write/read scheduler for `instr_register`. It arbitrates two instruction producers onto the register's single write port and manages `write_pointer`/`read_pointer` as a circular queue. It presents stored instructions to one consumer through a valid/ready handshake. It sits between the test/stimulus agents and `instr_register`, and drives the same `tb_ifc` signals that the bench previously drove directly.

## Interface
Parameters:
- `DEPTH`, 32: register entries; must be a power of two.
- `ADDR_W`, 5: `$clog2(DEPTH)`; width of both pointers.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  producer holds a request.
- `req0_opcode`, `req1_opcode`  in  `opcode_t`  requested opcode.
- `req0_op_a`/`req0_op_b`, `req1_op_a`/`req1_op_b`  in  `operand_t` (32 b signed)  operands.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `load_en`  out  1  write strobe to `instr_register`.
- `opcode`, `operand_a`, `operand_b`  out  `opcode_t`/`operand_t`  write data.
- `write_pointer`, `read_pointer`  out  `ADDR_W`  register addresses.
- `instruction_word`  in  `instruction_t`  combinational read data from the register at `read_pointer`.
- `out_valid`  out  1  an instruction is available to the consumer.
- `out_instr`  out  `instruction_t`  equals `instruction_word`.
- `out_ready`  in  1  consumer takes the instruction.
- `count`  out  `ADDR_W+1`  committed entries.
- `full`, `empty`  out  1  `count==DEPTH`, `count==0`.

## Operation
- Space check: `space = (count + load_en) < DEPTH`. The in-flight write counts against capacity.
- Grant (combinational) is evaluated only when `space` is 1.
  - Only one valid: that requester is granted.
  - Both valid: round-robin. The requester not granted last time wins.
- `reqN_ready` = grant N. A transfer occurs when `valid && ready`.
- Producers hold `valid` and payload stable until `ready`. Dropping `valid` without `ready` is legal; nothing is written.
- On transfer:
  - Register `load_en`=1, `opcode`/`operand_a`/`operand_b` = granted payload, and `write_pointer` = `wr_ptr`.
  - `wr_ptr` increments modulo DEPTH.
  - `last_grant` updates to the granted requester.
- No transfer: `load_en` registers 0. Data outputs hold their last value.
- Commit: the edge on which `load_en` is 1 writes the register and increments `count`.
- Read side:
  - `read_pointer` = `rd_ptr`.
  - `out_valid` = `!empty`.
  - `out_valid && out_ready` pops: `rd_ptr` increments modulo DEPTH and `count` decrements.
- Commit and pop on the same edge: `count` unchanged; both pointers advance.
- `out_ready` while empty: ignored; no state change.
- Pointers wrap from DEPTH-1 to 0 with no special handling.

## Timing
- Reset values:
  - `load_en`=0, `opcode`=ZERO, `operand_a`=`operand_b`=0.
  - `write_pointer`=`read_pointer`=0, `count`=0.
  - `empty`=1, `full`=0, `out_valid`=0.
  - `last_grant`=1, so req0 wins the first tie.
  - `ready` outputs are 0 while `reset_n` is low.
- Reset mid-operation: a pending `load_en` is dropped immediately (async clear). Queue contents are logically discarded.
- Latency, request to consumer:
  - Request accepted at edge k.
  - `load_en` high during cycle k→k+1.
  - Register written and `count` incremented at edge k+1.
  - `out_valid` rises after edge k+1.
  - Total: 2 edges from acceptance to availability.
- Maximum throughput: one write and one pop per cycle.
- Full: `ready` outputs are 0 in the same cycle `space` becomes 0, including when the last slot is held by the in-flight write.

## Configuration
- `INSTR_SCHED_FIXED_PRI_EN` defined: strict priority, req0 always wins ties, `last_grant` is not implemented. req1 can starve; this is accepted.
- Undefined (default): round-robin as above.

## Structure
- `instr_register_pkg` holds `opcode_t`, `operand_t`, `instruction_t`, and `DEPTH`/`ADDR_W` defaults. The scheduler imports it.
- One sub-module, `rr_arb2`: two requests plus an enable in, one-hot grant out, with the `last_grant` flop. The macro selects its fixed-priority variant.
- Pointers, count and the write-port register stay in `instr_reg_sched`.
- In `top`, instantiate between `tb_intf` and `instr_register dut`, on the same `clk`/`reset_n`.

## Test plan
- Reset: assert `reset_n`=0 mid-stream with `load_en`=1 → all outputs at reset values within the same cycle; `count`=0.
- Single write: req0 (ADD, 5, 3) accepted at edge k → `load_en`=1, `write_pointer`=0 in cycle k+1; `out_valid`=1 with `out_instr`={ADD,5,3} after edge k+1.
- Tie: req0 and req1 both valid for 4 cycles → grants alternate 0,1,0,1. With `INSTR_SCHED_FIXED_PRI_EN` → 0,0,0,0.
- Fill: 32 writes, `out_ready`=0 → `full`=1, `count`=32, both `ready` outputs 0. Pop one → exactly one more write accepted.
- Wrap: 40 writes interleaved with pops → `write_pointer` goes 31→0; instructions are read back in order with matching payloads.
- Simultaneous: write commit and pop on the same edge with `count`=5 → `count` stays 5; both pointers +1.
